// File: rtl/fft_stage_sequencer.sv
// Butterfly issue sequencer for an in-place radix-2 DIT FFT: walks every stage and
// butterfly, issues sample/twiddle addresses, and drains write-backs between stages.
module fft_stage_sequencer #(
    parameter int N             = 32,
    parameter int address_width = $clog2(N),
    parameter int stage_width   = $clog2($clog2(N)) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     wb_valid,
    output logic                     rd_en,
    output logic [address_width-1:0] rd_address1,
    output logic [address_width-1:0] rd_address2,
    output logic [address_width-2:0] tw_address,
    output logic [stage_width-1:0]   stage,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int LOG2N = $clog2(N);
    localparam int K_W   = address_width - 1;
    localparam logic [K_W-1:0]           K_LAST = K_W'(N / 2 - 1);
    localparam logic [K_W-1:0]           K_ONE  = K_W'(1);
    localparam logic [stage_width-1:0]   S_LAST = stage_width'(LOG2N - 1);
    localparam logic [stage_width-1:0]   S_ONE  = stage_width'(1);
    localparam logic [address_width-1:0] A_ONE  = address_width'(1);
    localparam logic [address_width:0]   O_ONE  = (address_width + 1)'(1);
    localparam logic [address_width:0]   O_ZERO = {(address_width + 1){1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_r;
    logic [stage_width-1:0]   stage_r;
    logic [K_W-1:0]           k_r;
    logic [address_width:0]   outstanding_r;
    logic                     rd_en_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     err_r;

    logic [K_W-1:0]           mask_s;
    logic [K_W-1:0]           pos_s;
    logic [K_W-1:0]           grp_s;
    logic [K_W-1:0]           tw_s;
    logic [address_width-1:0] span_s;
    logic [address_width-1:0] addr1_s;
    logic [address_width-1:0] addr2_s;

    // Sequencer FSM; rd_en/busy/done are registered alongside the state they decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            stage_r <= {stage_width{1'b0}};
            k_r     <= {K_W{1'b0}};
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= ISSUE;
                        stage_r <= {stage_width{1'b0}};
                        k_r     <= {K_W{1'b0}};
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (k_r == K_LAST) begin
                        state_r <= DRAIN;
                        rd_en_r <= 1'b0;
                    end else begin
                        k_r <= k_r + K_ONE;
                    end
                end
                // Leave only once the registered count shows every butterfly written back.
                DRAIN: begin
                    if (outstanding_r == O_ZERO) begin
                        if (stage_r == S_LAST) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ISSUE;
                            stage_r <= stage_r + S_ONE;
                            k_r     <= {K_W{1'b0}};
                            rd_en_r <= 1'b1;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // In-flight butterfly counter and sticky underflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_r <= O_ZERO;
            err_r         <= 1'b0;
        end else begin
            case ({rd_en_r, wb_valid})
                2'b10: outstanding_r <= outstanding_r + O_ONE;
                2'b01: begin
                    if (outstanding_r == O_ZERO) begin
                        err_r <= 1'b1;
                    end else begin
                        outstanding_r <= outstanding_r - O_ONE;
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Butterfly address equations from the registered stage and butterfly index.
    always_comb begin
        mask_s  = ~({K_W{1'b1}} << stage_r);
        pos_s   = k_r & mask_s;
        grp_s   = k_r >> stage_r;
        span_s  = A_ONE << stage_r;
        addr1_s = ({1'b0, grp_s} << (stage_r + S_ONE)) | {1'b0, pos_s};
        addr2_s = addr1_s + span_s;
        tw_s    = pos_s << (S_LAST - stage_r);
    end

    // Addresses are forced to zero whenever no butterfly is being issued.
    always_comb begin
        rd_address1 = {address_width{1'b0}};
        rd_address2 = {address_width{1'b0}};
        tw_address  = {K_W{1'b0}};
        if (rd_en_r) begin
            rd_address1 = addr1_s;
            rd_address2 = addr2_s;
            tw_address  = tw_s;
        end else begin
            rd_address1 = {address_width{1'b0}};
            rd_address2 = {address_width{1'b0}};
            tw_address  = {K_W{1'b0}};
        end
    end

    assign rd_en = rd_en_r;
    assign stage = stage_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: an N=8 instance with hand-computed address vectors and an
// N=32 instance for issue counting; write-backs return 6 cycles after issue.
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start8, start32, inject;
    logic [5:0] pipe8, pipe32;
    logic       wb8, wb32;

    logic       rd_en8, busy8, done8, err8;
    logic [2:0] a1_8, a2_8, stage8;
    logic [1:0] tw8;
    logic       rd_en32, busy32, done32, err32;
    logic [4:0] a1_32, a2_32;
    logic [3:0] tw32, stage32;

    fft_stage_sequencer #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .wb_valid(wb8),
        .rd_en(rd_en8), .rd_address1(a1_8), .rd_address2(a2_8), .tw_address(tw8),
        .stage(stage8), .busy(busy8), .done(done8), .err(err8)
    );

    fft_stage_sequencer dut32 (
        .clk(clk), .reset(reset), .start(start32), .wb_valid(wb32),
        .rd_en(rd_en32), .rd_address1(a1_32), .rd_address2(a2_32), .tw_address(tw32),
        .stage(stage32), .busy(busy32), .done(done32), .err(err32)
    );

    // Write-back model: each issue returns 6 cycles later; an injected early
    // write-back replaces the delayed one for the butterfly issued that cycle.
    assign wb8  = pipe8[5] | inject;
    assign wb32 = pipe32[5];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe8  <= 6'd0;
            pipe32 <= 6'd0;
        end else begin
            pipe8  <= {pipe8[4:0], rd_en8 & ~inject};
            pipe32 <= {pipe32[4:0], rd_en32};
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int rd1;
        int rd2;
        int tw;
        int stg;
    } exp_t;
    exp_t sb[$];

    int tab[36] = '{0,1,0, 2,3,0, 4,5,0, 6,7,0,
                    0,2,0, 1,3,2, 4,6,0, 5,7,2,
                    0,4,0, 1,5,1, 2,6,2, 3,7,3};

    task automatic push_transform();
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e.rd1 = tab[3*i];
            e.rd2 = tab[3*i+1];
            e.tw  = tab[3*i+2];
            e.stg = i / 4;
            sb.push_back(e);
        end
    endtask

    // N=8 monitor: pops the scoreboard on every issue and checks stage gating.
    int   cyc = 0, n_iss = 0, n_wb = 0, last_iss = 0;
    exp_t got;
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            n_iss = 0;
            n_wb  = 0;
        end else begin
            if (rd_en8) begin
                if (sb.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk("rd_address1", int'(a1_8), got.rd1);
                    chk("rd_address2", int'(a2_8), got.rd2);
                    chk("tw_address", int'(tw8), got.tw);
                    chk("stage", int'(stage8), got.stg);
                end
                if (n_iss > 0 && n_iss % 4 == 0) begin
                    chk("drain_gap", cyc - last_iss, 8);
                    chk("wb_before_next_stage", n_wb, n_iss);
                end
                last_iss = cyc;
                n_iss++;
            end
            if (wb8 && busy8) n_wb++;
            if (done8) begin
                chk("issues_per_transform", n_iss, 12);
                chk("wb_per_transform", n_wb, 12);
                n_iss = 0;
                n_wb  = 0;
            end
        end
    end

    // N=32 monitor: issue count, stage progression and a few spot addresses.
    int iss32 = 0, dn32 = 0;
    always @(negedge clk) begin
        if (reset && rd_en32) begin
            chk("stage32", int'(stage32), iss32 / 16);
            if (iss32 == 5) begin
                chk("n32_rd1_s0k5", int'(a1_32), 10);
                chk("n32_rd2_s0k5", int'(a2_32), 11);
                chk("n32_tw_s0k5", int'(tw32), 0);
            end
            if (iss32 == 17) begin
                chk("n32_rd1_s1k1", int'(a1_32), 1);
                chk("n32_rd2_s1k1", int'(a2_32), 3);
                chk("n32_tw_s1k1", int'(tw32), 8);
            end
            if (iss32 == 79) begin
                chk("n32_rd1_s4k15", int'(a1_32), 15);
                chk("n32_rd2_s4k15", int'(a2_32), 31);
                chk("n32_tw_s4k15", int'(tw32), 15);
            end
            iss32++;
        end
        if (reset && done32) dn32++;
    end

    task automatic wait_done8(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!done8 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!done8) chk("done8_timeout", 0, 1);
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, int'(rd_en8), 0);
        chk({tag, "_rd1"}, int'(a1_8), 0);
        chk({tag, "_rd2"}, int'(a2_8), 0);
        chk({tag, "_tw"}, int'(tw8), 0);
        chk({tag, "_stage"}, int'(stage8), 0);
        chk({tag, "_busy"}, int'(busy8), 0);
        chk({tag, "_done"}, int'(done8), 0);
        chk({tag, "_err"}, int'(err8), 0);
    endtask

    initial begin
        reset   = 1'b0;
        start8  = 1'b0;
        start32 = 1'b0;
        inject  = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic N=8 transform with start toggling while busy.
        push_transform();
        pulse_start8();
        repeat (20) begin
            @(posedge clk);
            #1 start8 = ~start8;
        end
        start8 = 1'b0;
        wait_done8(200);
        chk("busy_in_done", int'(busy8), 1);
        @(negedge clk);
        chk("busy_after_done", int'(busy8), 0);
        chk("done_single_pulse", int'(done8), 0);
        chk("err_clean", int'(err8), 0);
        chk("sb_empty_a", sb.size(), 0);

        // Abort during stage 1, then a fresh transform.
        @(posedge clk);
        #1 push_transform();
        pulse_start8();
        begin
            int n = 0;
            while (!(rd_en8 && stage8 == 3'd1) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_stage1", int'(rd_en8 && stage8 == 3'd1), 1);
        end
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 push_transform();
        pulse_start8();
        wait_done8(200);
        chk("err_after_abort", int'(err8), 0);

        // Write-back coincident with the first issue of a transform.
        @(posedge clk);
        #1 push_transform();
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        inject = 1'b1;
        chk("coincident_issue", int'(rd_en8), 1);
        @(posedge clk);
        #1 inject = 1'b0;
        wait_done8(200);
        chk("err_after_coincident", int'(err8), 0);

        // Start held high: two back-to-back transforms separated by DONE + IDLE.
        @(posedge clk);
        #1 push_transform();
        push_transform();
        start8 = 1'b1;
        wait_done8(200);
        @(negedge clk);
        chk("idle_gap_rd_en", int'(rd_en8), 0);
        chk("idle_gap_busy", int'(busy8), 0);
        @(negedge clk);
        chk("restart_rd_en", int'(rd_en8), 1);
        wait_done8(200);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stays_idle", int'(busy8), 0);
        chk("sb_empty_d", sb.size(), 0);

        // Write-back in IDLE sets a sticky error.
        @(posedge clk);
        #1 inject = 1'b1;
        @(posedge clk);
        #1 inject = 1'b0;
        chk("err_set", int'(err8), 1);
        push_transform();
        pulse_start8();
        wait_done8(200);
        chk("err_sticky", int'(err8), 1);

        // Default N=32 transform.
        @(posedge clk);
        #1 start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        begin
            int n = 0;
            while (!done32 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("done32_seen", int'(done32), 1);
        end
        repeat (5) @(negedge clk);
        chk("n32_issue_count", iss32, 80);
        chk("n32_done_count", dn32, 1);
        chk("n32_err", int'(err32), 0);
        chk("n32_busy_end", int'(busy32), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
